// File: rtl/log_stream_if.sv
// log_stream_if: frame handshake bundle for log_stream.
// The master side supplies input frames and takes results; the slave side is the converter.
interface log_stream_if #(
    parameter int I_BW = 30,
    parameter int O_BW = 14,
    parameter int N_CH = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [I_BW*N_CH-1:0]   data_i;
    logic                   out_valid;
    logic                   out_ready;
    logic [O_BW*N_CH-1:0]   data_o;
    logic                   busy;

    modport master (
        output in_valid, data_i, out_ready,
        input  in_ready, out_valid, data_o, busy
    );

    modport slave (
        input  in_valid, data_i, out_ready,
        output in_ready, out_valid, data_o, busy
    );
endinterface

// File: rtl/log_stream.sv
// log_stream: converts a frame of N_CH unsigned channels into scaled log2 values,
// LANES channels per clock. Each channel gives floor(L*5/7), where L is the bit
// length plus SHIFT. The result saturates at 2^(O_BW-1)-1.
// Optional feature macro LOG_FRAC_EN adds FRAC mantissa bits below the leading one.
// When the macro is enabled, L = ((k+SHIFT)<<FRAC)+f.
module log_stream #(
    parameter int I_BW  = 30,
    parameter int O_BW  = 14,
    parameter int SHIFT = 10,
    parameter int N_CH  = 64,
    parameter int LANES = 4,
    parameter int FRAC  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    log_stream_if.slave bus
);
    localparam int NB  = N_CH / LANES;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int SAT = (1 << (O_BW - 1)) - 1;

    // Reject channel/lane splits that leave a partial last batch.
    if ((N_CH % LANES) != 0 || FRAC < 1) begin : g_param_check
        $error("log_stream: N_CH must be a multiple of LANES and FRAC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_reg;
    logic [BW-1:0]        batch_reg;
    logic [I_BW*N_CH-1:0] in_buf_reg;
    logic [O_BW*N_CH-1:0] data_o_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic                 busy_reg;
    logic [O_BW-1:0]      lane_res [LANES];

    // Per-channel conversion: bit length k, optional mantissa, scale by 5/7, saturate.
    function automatic logic [O_BW-1:0] conv(input logic [I_BW-1:0] x);
        int k;
        int l;
        int q;
`ifdef LOG_FRAC_EN
        logic [I_BW+FRAC-1:0] ext;
        logic [FRAC-1:0]      f;
`endif
        k = 0;
        for (int i = 0; i < I_BW; i++) begin
            if (x[i]) k = i + 1;
        end
`ifdef LOG_FRAC_EN
        // Left-justify x so the leading one sits in the top bit; the FRAC bits
        // beneath it are the mantissa. The appended zeros give the right padding.
        ext = {x, {FRAC{1'b0}}} << (I_BW - k);
        f   = (k <= 1) ? '0 : ext[I_BW+FRAC-2 -: FRAC];
        l   = ((k + SHIFT) << FRAC) + int'(f);
`else
        l = k + SHIFT;
`endif
        q = (l * 5) / 7;
        if (q < 0)   q = 0;
        if (q > SAT) q = SAT;
        return q[O_BW-1:0];
    endfunction

    // Lane converters read the channels selected by the current batch.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_res[gi] = conv(in_buf_reg[(int'(batch_reg) * LANES + gi) * I_BW +: I_BW]);
    end

    // Control FSM: accept in IDLE, convert one batch per edge, hold result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            batch_reg     <= '0;
            in_buf_reg    <= '0;
            data_o_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_buf_reg   <= bus.data_i;
                        batch_reg    <= '0;
                        state_reg    <= CONV;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                CONV: begin
                    for (int li = 0; li < LANES; li++) begin
                        data_o_reg[(int'(batch_reg) * LANES + li) * O_BW +: O_BW] <= lane_res[li];
                    end
                    if (batch_reg == BW'(NB - 1)) begin
                        // Park the counter at zero so the lane selects stay in range.
                        batch_reg     <= '0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        batch_reg <= batch_reg + BW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.data_o    = data_o_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_log_stream.sv
// tb_log_stream: table-driven check of log_stream at LANES=4 (defaults), LANES=1
// with a narrow saturating output, and LANES=64, plus handshake and reset sequences.
module tb_log_stream;
    localparam int IW  = 30;
    localparam int OW  = 14;
    localparam int OWS = 5;
    localparam int NC  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    log_stream_if #(.I_BW(IW), .O_BW(OW),  .N_CH(NC)) ba ();
    log_stream_if #(.I_BW(IW), .O_BW(OWS), .N_CH(NC)) bb ();
    log_stream_if #(.I_BW(IW), .O_BW(OW),  .N_CH(NC)) bc ();

    log_stream #(.I_BW(IW), .O_BW(OW), .SHIFT(10), .N_CH(NC), .LANES(4), .FRAC(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    log_stream #(.I_BW(IW), .O_BW(OWS), .SHIFT(10), .N_CH(NC), .LANES(1), .FRAC(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    log_stream #(.I_BW(IW), .O_BW(OW), .SHIFT(10), .N_CH(NC), .LANES(64), .FRAC(4))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));

    typedef struct {
        logic [IW-1:0] x;
        int            exp;
    } vec_t;

    vec_t vt[12];
    logic [IW-1:0] xs[12] = '{30'd0, 30'd1, 30'd2, 30'd3, 30'd4, 30'd255, 30'd256,
                              30'd1023, 30'h2000_0000, 30'h3FFF_FFFF, 30'd12345, 30'h10_0000};
    int ei[12] = '{7, 7, 8, 8, 9, 12, 13, 14, 28, 28, 17, 22};
    int ef[12] = '{114, 125, 137, 142, 148, 216, 217, 239, 457, 467, 280, 354};

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: bit length by shifting down until empty, mantissa by arithmetic shift.
    function automatic int ref_conv(input logic [IW-1:0] x, input int obw);
        longint xv;
        longint l;
        longint q;
        longint sat;
        int     k;
        xv = longint'(x);
        k  = 0;
        while ((xv >> k) != 0) k++;
`ifdef LOG_FRAC_EN
        l = longint'((k + 10) * 16) + ((k >= 1) ? (((xv << 4) >> (k - 1)) & 15) : 0);
`else
        l = longint'(k + 10);
`endif
        q   = (l * 5) / 7;
        sat = (longint'(1) << (obw - 1)) - 1;
        return int'((q > sat) ? sat : q);
    endfunction

    function automatic logic [IW-1:0] rnd30();
        logic [IW-1:0] v;
        int w;
        w = $urandom_range(0, 30);
        v = IW'($urandom);
        if (w < 30) v = v & ((30'd1 << w) - 30'd1);
        return v;
    endfunction

    // Send one frame to all three instances, then check latency, handshake and data.
    task automatic run_frame(input logic [IW*NC-1:0] frame, input logic [OW*NC-1:0] exp_a,
                             input string tag);
        int  la, lb, lc;
        logic rdy_ok;
        check({tag, " in_ready before accept"}, longint'(ba.in_ready), 1);
        ba.data_i = frame; bb.data_i = frame; bc.data_i = frame;
        ba.in_valid = 1'b1; bb.in_valid = 1'b1; bc.in_valid = 1'b1;
        @(posedge clk); #1;
        ba.in_valid = 1'b0; bb.in_valid = 1'b0; bc.in_valid = 1'b0;
        la = -1; lb = -1; lc = -1; rdy_ok = 1'b1;
        for (int n = 0; n <= 80; n++) begin
            if (la < 0 && ba.out_valid) la = n;
            if (lb < 0 && bb.out_valid) lb = n;
            if (lc < 0 && bc.out_valid) lc = n;
            if (la < 0 && (ba.in_ready || !ba.busy)) rdy_ok = 1'b0;
            if (la >= 0 && lb >= 0 && lc >= 0) break;
            @(posedge clk); #1;
        end
        check({tag, " latency lanes4"}, la, 16);
        check({tag, " latency lanes1"}, lb, 64);
        check({tag, " latency lanes64"}, lc, 1);
        check({tag, " in_ready0/busy1 while converting"}, longint'(rdy_ok), 1);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s lanes4 ch%0d", tag, c),
                  longint'(ba.data_o[c*OW +: OW]), longint'(exp_a[c*OW +: OW]));
            check($sformatf("%s lanes1 ch%0d", tag, c),
                  longint'(bb.data_o[c*OWS +: OWS]), ref_conv(frame[c*IW +: IW], OWS));
            check($sformatf("%s lanes64 ch%0d", tag, c),
                  longint'(bc.data_o[c*OW +: OW]), ref_conv(frame[c*IW +: IW], OW));
        end
        ba.out_ready = 1'b1; bb.out_ready = 1'b1; bc.out_ready = 1'b1;
        @(posedge clk); #1;
        ba.out_ready = 1'b0; bb.out_ready = 1'b0; bc.out_ready = 1'b0;
        check({tag, " out_valid after take"}, longint'(ba.out_valid | bb.out_valid | bc.out_valid), 0);
        check({tag, " in_ready after take"}, longint'(ba.in_ready & bb.in_ready & bc.in_ready), 1);
    endtask

    initial begin
        logic [IW*NC-1:0] frame;
        logic [IW*NC-1:0] frame2;
        logic [OW*NC-1:0] expv;
        int               la;
        int               seen;

        for (int i = 0; i < 12; i++) begin
`ifdef LOG_FRAC_EN
            vt[i] = '{xs[i], ef[i]};
`else
            vt[i] = '{xs[i], ei[i]};
`endif
        end

        ba.in_valid = 1'b0; ba.out_ready = 1'b0; ba.data_i = '0;
        bb.in_valid = 1'b0; bb.out_ready = 1'b0; bb.data_i = '0;
        bc.in_valid = 1'b0; bc.out_ready = 1'b0; bc.data_i = '0;

        // Reset state.
        #12;
        check("reset out_valid", longint'(ba.out_valid), 0);
        check("reset in_ready", longint'(ba.in_ready), 1);
        check("reset busy", longint'(ba.busy), 0);
        check("reset data_o zero", longint'(ba.data_o == '0), 1);
        rst_n = 1'b1;

        // Uniform frames (0, 1, 2^29), first one accepted on the first edge after release.
        for (int p = 0; p < 3; p++) begin
            int idx;
            idx = (p == 0) ? 0 : ((p == 1) ? 1 : 8);
            for (int c = 0; c < NC; c++) begin
                frame[c*IW +: IW] = vt[idx].x;
                expv[c*OW +: OW]  = OW'(vt[idx].exp);
            end
            run_frame(frame, expv, $sformatf("uniform%0d", idx));
        end

        // Mixed frames: rotate the table across channels.
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < NC; c++) begin
                frame[c*IW +: IW] = vt[(c + f) % 12].x;
                expv[c*OW +: OW]  = OW'(vt[(c + f) % 12].exp);
            end
            run_frame(frame, expv, $sformatf("table%0d", f));
        end

        // Random frames checked against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NC; c++) begin
                frame[c*IW +: IW] = rnd30();
                expv[c*OW +: OW]  = OW'(ref_conv(frame[c*IW +: IW], OW));
            end
            run_frame(frame, expv, $sformatf("random%0d", r));
        end

        // Hold in DONE with out_ready low while a second frame is offered.
        for (int c = 0; c < NC; c++) begin
            frame[c*IW +: IW]  = vt[c % 12].x;
            frame2[c*IW +: IW] = vt[(c + 5) % 12].x;
            expv[c*OW +: OW]   = OW'(vt[c % 12].exp);
        end
        ba.data_i = frame; ba.in_valid = 1'b1;
        @(posedge clk); #1;
        ba.in_valid = 1'b0;
        la = -1;
        for (int n = 0; n <= 40; n++) begin
            if (ba.out_valid) begin la = n; break; end
            @(posedge clk); #1;
        end
        check("hold latency", la, 16);
        ba.data_i = frame2; ba.in_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            check($sformatf("hold%0d out_valid", h), longint'(ba.out_valid), 1);
            check($sformatf("hold%0d data stable", h), longint'(ba.data_o == expv), 1);
            check($sformatf("hold%0d in_ready", h), longint'(ba.in_ready), 0);
            @(posedge clk); #1;
        end
        ba.in_valid = 1'b0; ba.out_ready = 1'b1;
        @(posedge clk); #1;
        ba.out_ready = 1'b0;
        check("hold release out_valid", longint'(ba.out_valid), 0);
        check("hold release in_ready", longint'(ba.in_ready), 1);
        check("hold release busy", longint'(ba.busy), 0);

        // Reset in the middle of conversion.
        ba.data_i = frame; ba.in_valid = 1'b1;
        @(posedge clk); #1;
        ba.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", longint'(ba.out_valid), 0);
        check("midreset data_o zero", longint'(ba.data_o == '0), 1);
        check("midreset busy", longint'(ba.busy), 0);
        check("midreset in_ready", longint'(ba.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ba.out_valid) seen = 1;
        end
        check("no out_valid after reset", seen, 0);
        check("in_ready after reset", longint'(ba.in_ready), 1);
        for (int c = 0; c < NC; c++) begin
            frame[c*IW +: IW] = vt[(c + 7) % 12].x;
            expv[c*OW +: OW]  = OW'(vt[(c + 7) % 12].exp);
        end
        run_frame(frame, expv, "postreset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
